spi_controller: RTL and testbench
=================================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter CLK_DIV, default 4, SHALL set the SCLK half-period in clk cycles; legal range 2..255.
REQ-002 Parameter CS_SETUP, default 4, SHALL set the clk cycles from nCS falling to the first SCLK rising edge window start; legal range 1..255.
REQ-003 Parameter CS_HOLD, default 8, SHALL set the clk cycles nCS stays low after the last SCLK falling edge; legal range 1..255.
REQ-004 Parameter CS_GAP, default 4, SHALL set the minimum clk cycles nCS stays high between frames; legal range 1..255.
REQ-005 clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-006 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-007 req_valid  input  1  SHALL indicate that a write request is offered.
REQ-008 req_addr  input  7  SHALL be the target register address.
REQ-009 req_data  input  8  SHALL be the register write data.
REQ-010 req_ready  output  1  SHALL be high when a request can be accepted.
REQ-011 busy  output  1  SHALL be high while a frame is in progress (any state except IDLE).
REQ-012 done  output  1  SHALL pulse high for one cycle when a frame completes.
REQ-013 SCLK  output  1  SHALL be the serial clock, idle low.
REQ-014 nCS  output  1  SHALL be the active-low chip select, idle high.
REQ-015 COPI  output  1  SHALL be the serial data output.

Function
REQ-016 A request SHALL be accepted on a cycle where req_valid && req_ready; req_ready SHALL be high only in IDLE.
REQ-017 On acceptance, the block SHALL latch frame = {1'b1, req_addr, req_data}; bit 15 is the write flag. Input changes after acceptance SHALL be ignored.
REQ-018 The FSM SHALL have exactly these states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-019 On the cycle after acceptance, the FSM SHALL enter SETUP, drive nCS=0, and drive COPI=frame[15]; SETUP SHALL last CS_SETUP cycles.
REQ-020 SHIFT SHALL transmit 16 bits, MSB first, SPI mode 0; each bit SHALL hold SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-021 COPI SHALL change only while SCLK is low: at SHIFT entry and on each SCLK falling edge. It SHALL be stable across every rising edge.
REQ-022 After the 16th high phase, SCLK SHALL return low and the FSM SHALL enter HOLD for CS_HOLD cycles with nCS=0.
REQ-023 The FSM SHALL then drive nCS=1 and COPI=0 and enter GAP for CS_GAP cycles.
REQ-024 The FSM SHALL then enter IDLE with done=1 for that single cycle; req_ready SHALL be high in the same cycle.
REQ-025 A request presented in the done cycle SHALL be accepted; back-to-back frames SHALL be separated by nCS high for at least CS_GAP+1 cycles.
REQ-026 The frame length from acceptance to the done cycle SHALL be exactly 1+CS_SETUP+32*CLK_DIV+CS_HOLD+CS_GAP cycles, which is 145 with defaults.
REQ-027 The bit counter SHALL be 5 bits and the phase timer 8 bits; neither SHALL wrap within a frame.
REQ-028 SCLK, nCS and COPI SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-029 When rst=1, the next state SHALL be IDLE with SCLK=0, nCS=1, COPI=0, done=0, busy=0, and counters cleared; req_ready SHALL be 0 while rst=1.
REQ-030 Reset mid-frame SHALL abort the frame on the next edge with no done pulse; the truncated frame (fewer than 16 edges) SHALL be discarded by the peripheral.

Structure
REQ-031 Shared package spi_pkg SHALL hold FRAME_W=16, ADDR_W=7, DATA_W=8, the register address constants 0x00-0x04, and the FSM state enum.
REQ-032 One sub-module, spi_timer, SHALL be used: a loadable down-counter with a zero flag that times the SETUP, half-bit, HOLD and GAP intervals.

Verification
REQ-033 Write addr=0x04, data=0xA5 with defaults: COPI sampled at the SCLK rising edges SHALL read 0x84A5; done SHALL arrive 145 cycles after acceptance.
REQ-034 Two back-to-back requests (0x00/0xFF, 0x01/0x0F) with req_valid held high: two frames SHALL be sent with nCS high for at least 5 cycles between them, and two done pulses.
REQ-035 Assert rst during bit 7 of SHIFT: nCS=1, SCLK=0 and COPI=0 on the next edge, no done pulse; a following request SHALL complete normally.
REQ-036 With CLK_DIV=2: SCLK period SHALL be 4 cycles; a COPI-change-while-SCLK-high assertion SHALL never fire.
REQ-037 Closed loop with spi_peripheral writing addresses 0x00-0x04, then 0x05: registers SHALL match the data written; 0x05 SHALL leave all registers unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI write controller
// and its peripheral-side register map.
package spi_pkg;
  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam logic [ADDR_W-1:0] REG_CTRL   = 7'h00;
  localparam logic [ADDR_W-1:0] REG_STATUS = 7'h01;
  localparam logic [ADDR_W-1:0] REG_CFG    = 7'h02;
  localparam logic [ADDR_W-1:0] REG_DATA   = 7'h03;
  localparam logic [ADDR_W-1:0] REG_IRQ    = 7'h04;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_controller_if.sv
// Request handshake and serial pins of the SPI controller; the slave
// modport is the controller view, the master modport the requester view.
interface spi_controller_if;
  logic                        req_valid;
  logic [spi_pkg::ADDR_W-1:0]  req_addr;
  logic [spi_pkg::DATA_W-1:0]  req_data;
  logic                        req_ready;
  logic                        busy;
  logic                        done;
  logic                        SCLK;
  logic                        nCS;
  logic                        COPI;

  modport master (output req_valid, req_addr, req_data,
                  input  req_ready, busy, done, SCLK, nCS, COPI);
  modport slave  (input  req_valid, req_addr, req_data,
                  output req_ready, busy, done, SCLK, nCS, COPI);
endinterface

// File: rtl/spi_timer.sv
// Loadable down-counter: load_val+1 cycles elapse from load until zero
// is seen high, so a state lasting N cycles loads N-1.
module spi_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write-only controller: one 16-bit frame {1, addr, data} per
// accepted request, framed by programmable nCS setup, hold and gap times.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 8,
  parameter int CS_GAP   = 4
) (
  input  logic           clk,
  input  logic           rst,
  spi_controller_if.slave bus
);
  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
  localparam logic [7:0] HALF_LD  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LD   = 8'(CS_GAP - 1);

  state_t               state;
  logic [FRAME_W-1:0]   frame;
  logic [4:0]           bit_cnt;
  logic                 sclk_q, ncs_q, copi_q, done_q;
  logic                 accept, t_zero, t_load;
  logic [7:0]           t_val;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.SCLK      = sclk_q;
  assign bus.nCS       = ncs_q;
  assign bus.COPI      = copi_q;
  assign accept        = bus.req_valid && bus.req_ready;

  // Timer reload value is chosen for the interval that starts next.
  always_comb begin
    t_val = '0;
    case (state)
      IDLE:    t_val = SETUP_LD;
      SETUP:   t_val = HALF_LD;
      SHIFT:   t_val = (sclk_q && bit_cnt == 5'd15) ? HOLD_LD : HALF_LD;
      HOLD:    t_val = GAP_LD;
      default: t_val = '0;
    endcase
  end

  assign t_load = accept || (state != IDLE && t_zero);

  spi_timer #(.W(8)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      frame   <= '0;
      bit_cnt <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          frame  <= {1'b1, bus.req_addr, bus.req_data};
          state  <= SETUP;
          ncs_q  <= 1'b0;
          copi_q <= 1'b1;
        end
        SETUP: if (t_zero) begin
          state   <= SHIFT;
          bit_cnt <= '0;
        end
        SHIFT: if (t_zero) begin
          if (!sclk_q) begin
            sclk_q <= 1'b1;
          end else begin
            // Falling edge: present the next bit while SCLK is low.
            sclk_q <= 1'b0;
            if (bit_cnt == 5'd15) begin
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              frame   <= {frame[FRAME_W-2:0], 1'b0};
              copi_q  <= frame[FRAME_W-2];
            end
          end
        end
        HOLD: if (t_zero) begin
          state  <= GAP;
          ncs_q  <= 1'b1;
          copi_q <= 1'b0;
        end
        GAP: if (t_zero) begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_controller.sv
// Randomized bench: cycle-indexed waveform model of each frame, a register
// peripheral fed from the serial pins, and a CLK_DIV=2 timing instance.
module tb_spi_controller;
  localparam int S = 4, D = 4, H = 8, G = 4;
  localparam int N = 1 + S + 32*D + H + G;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_controller_if bus ();
  spi_controller_if bus2 ();

  spi_controller u_dut (.clk(clk), .rst(rst), .bus(bus));
  spi_controller #(.CLK_DIV(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, act, exp, $time);
    end
  endtask

  // Expected {dc_copi, ready, busy, done, nCS, SCLK, COPI} at cycle t of a frame.
  function automatic logic [6:0] expect_out(input int t, input logic [15:0] f, input logic r);
    int k;
    if (t == 0 || t == N)        return {1'b0, !r, 1'b0, (t == N), 1'b1, 1'b0, 1'b0};
    else if (t <= S)             return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, f[15]};
    else if (t <= S + 32*D) begin
      k = t - S - 1;
      return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ((k % (2*D)) >= D), f[15 - k/(2*D)]};
    end
    else if (t <= S + 32*D + H)  return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    else                         return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction

  int t = 0, cyc = 0, acc_cyc = 0, acc2_cyc = 0;
  logic [15:0] mf = '0, f2 = '0;
  bit acc_seen = 0, acc2_seen = 0, done2_seen = 0;

  always @(posedge clk) begin
    if (rst) t = 0;
    else if ((t == 0 || t == N) && bus.req_valid) begin
      t = 1; mf = {1'b1, bus.req_addr, bus.req_data}; acc_seen = 1; acc_cyc = cyc;
    end
    else if (t == N) t = 0;
    else if (t != 0) t++;
    if (!rst && bus2.req_valid && bus2.req_ready) begin acc2_seen = 1; acc2_cyc = cyc; end
    cyc++;
  end

  logic [7:0]  regs [0:4] = '{default: 8'h00};
  logic [7:0]  exp_regs [0:4] = '{default: 8'h00};
  logic [15:0] sh = '0, last_word = '0, sh2 = '0, last_word2 = '0;
  int pcnt = 0, done_cnt = 0, last_lat = 0, ncs_run = 0, min_gap = 1000, last_rise2 = 0;
  bit gap_arm = 0, rise2_seen = 0;
  logic sclk_prev = 0, ncs_prev = 1, copi_prev = 0, sclk2_prev = 0, ncs2_prev = 1, copi2_prev = 0;

  always @(negedge clk) begin
    logic [6:0] ex;
    logic [5:0] act, m;
    ex  = expect_out(t, mf, rst);
    act = {bus.req_ready, bus.busy, bus.done, bus.nCS, bus.SCLK, bus.COPI};
    m   = ex[6] ? 6'b111110 : 6'b111111;
    chk("outputs{rdy,busy,done,ncs,sclk,copi}", 32'(act & m), 32'(ex[5:0] & m));
    if (bus.SCLK) chk("copi_stable_sclk_high", 32'(bus.COPI), 32'(copi_prev));
    // Peripheral: shift on SCLK rise, commit a complete frame when nCS rises.
    if (!bus.nCS && bus.SCLK && !sclk_prev) begin sh = {sh[14:0], bus.COPI}; pcnt++; end
    if (bus.nCS && !ncs_prev) begin
      last_word = sh;
      if (pcnt == 16 && sh[15] && sh[14:8] < 7'd5) regs[int'(sh[14:8])] = sh[7:0];
    end
    if (!bus.nCS && ncs_prev) begin
      pcnt = 0; sh = '0;
      if (gap_arm && ncs_run < min_gap) min_gap = ncs_run;
      gap_arm = 1;
    end
    ncs_run = bus.nCS ? ncs_run + 1 : 0;
    if (bus.done) begin done_cnt++; last_lat = cyc - acc_cyc; end
    sclk_prev = bus.SCLK; ncs_prev = bus.nCS; copi_prev = bus.COPI;

    if (bus2.SCLK) chk("dut2_copi_stable_sclk_high", 32'(bus2.COPI), 32'(copi2_prev));
    if (!bus2.nCS && ncs2_prev) begin rise2_seen = 0; sh2 = '0; end
    if (!bus2.nCS && bus2.SCLK && !sclk2_prev) begin
      if (rise2_seen) chk("dut2_sclk_period", 32'(cyc - last_rise2), 32'd4);
      rise2_seen = 1; last_rise2 = cyc; sh2 = {sh2[14:0], bus2.COPI};
    end
    if (bus2.done) begin
      done2_seen = 1; last_word2 = sh2;
      chk("dut2_latency", 32'(cyc - acc2_cyc), 32'd81);
      chk("dut2_word", 32'(sh2), 32'(f2));
    end
    sclk2_prev = bus2.SCLK; ncs2_prev = bus2.nCS; copi2_prev = bus2.COPI;
  end

  task automatic send(input logic [6:0] a, input logic [7:0] d, input bit keep);
    acc_seen = 0; bus.req_addr = a; bus.req_data = d; bus.req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin @(posedge clk); #1; if (acc_seen) break; end
    if (!acc_seen) chk("accept_timeout", 32'd0, 32'd1);
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin @(posedge clk); #1; if (t == 0) break; end
    if (t != 0) chk("idle_timeout", 32'(t), 32'd0);
  endtask

  task automatic send2(input logic [6:0] a, input logic [7:0] d);
    acc2_seen = 0; done2_seen = 0; f2 = {1'b1, a, d};
    bus2.req_addr = a; bus2.req_data = d; bus2.req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin @(posedge clk); #1; if (acc2_seen) break; end
    bus2.req_valid = 1'b0;
    if (!acc2_seen) chk("dut2_accept_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 300; i++) begin @(posedge clk); #1; if (done2_seen) break; end
    if (!done2_seen) chk("dut2_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] dv, r2;
    logic [6:0] av;
    int d0, gap;
    bit keep;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0;
    bus2.req_valid = 1'b0; bus2.req_addr = '0; bus2.req_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_ncs", 32'(bus.nCS), 32'd1);
    chk("rst_sclk", 32'(bus.SCLK), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    send(7'h04, 8'hA5, 0); wait_idle();
    chk("word_84A5", 32'(last_word), 32'h84A5);
    chk("latency_145", 32'(last_lat), 32'd145);
    chk("reg4_A5", 32'(regs[4]), 32'hA5);

    done_cnt = 0; gap_arm = 0; min_gap = 1000;
    send(7'h00, 8'hFF, 1); send(7'h01, 8'h0F, 0); wait_idle();
    chk("b2b_done_pulses", 32'(done_cnt), 32'd2);
    chk("b2b_gap_ge5", 32'(min_gap >= 5), 32'd1);
    chk("b2b_reg0", 32'(regs[0]), 32'hFF);
    chk("b2b_reg1", 32'(regs[1]), 32'h0F);

    d0 = done_cnt; r2 = regs[2];
    send(7'h02, 8'h3C, 0);
    repeat (S + 14*D + 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_ncs", 32'(bus.nCS), 32'd1);
    chk("abort_sclk", 32'(bus.SCLK), 32'd0);
    chk("abort_copi", 32'(bus.COPI), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    chk("abort_reg2_kept", 32'(regs[2]), 32'(r2));
    send(7'h02, 8'h3C, 0); wait_idle();
    chk("after_abort_reg2", 32'(regs[2]), 32'h3C);

    exp_regs = regs;
    for (int a = 0; a < 5; a++) begin
      dv = 8'($urandom); send(7'(a), dv, 0); wait_idle(); exp_regs[a] = dv;
    end
    for (int a = 0; a < 5; a++) chk("loop_reg", 32'(regs[a]), 32'(exp_regs[a]));
    send(7'h05, 8'($urandom), 0); wait_idle();
    for (int a = 0; a < 5; a++) chk("addr5_no_write", 32'(regs[a]), 32'(exp_regs[a]));

    for (int i = 0; i < 20; i++) begin
      av = 7'($urandom_range(0, 7)); dv = 8'($urandom);
      keep = (i != 19) && ($urandom_range(0, 1) == 1);
      send(av, dv, keep);
      if (av < 7'd5) exp_regs[int'(av)] = dv;
      if (!keep) begin gap = $urandom_range(0, 10); repeat (gap) @(posedge clk); end
    end
    wait_idle();
    for (int a = 0; a < 5; a++) chk("rand_reg", 32'(regs[a]), 32'(exp_regs[a]));

    send2(7'h03, 8'h5A);
    chk("dut2_word_835A", 32'(last_word2), 32'h835A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
